// File: rtl/control_unit_multi_pkg.sv
// Shared definitions for the multi-pipeline command decoder.
// Holds the command-byte field positions, opcode values, the state
// encoding and small helpers used by the top and the byte collector.
package control_unit_multi_pkg;

  // Command byte layout: [7:4] opcode, [3:0] pipeline index
  localparam int CMD_OP_MSB   = 7;
  localparam int CMD_OP_LSB   = 4;
  localparam int CMD_PIPE_MSB = 3;
  localparam int CMD_PIPE_LSB = 0;

  localparam logic [3:0] OP_WRITE_INSTR     = 4'd1;
  localparam logic [3:0] OP_WRITE_REG       = 4'd2;
  localparam logic [3:0] OP_UPDATE_REG      = 4'd3;
  localparam logic [3:0] OP_ALLOC_SRAM      = 4'd4;
  localparam logic [3:0] OP_SWAP            = 4'd5;
  localparam logic [3:0] OP_RESET_PIPELINE  = 4'd6;
  localparam logic [3:0] OP_SET_INPUT_GAIN  = 4'd7;
  localparam logic [3:0] OP_SET_OUTPUT_GAIN = 4'd8;

  // Encodings are visible on control_state, so they are fixed explicitly
  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_BEGIN     = 3'd1,
    ST_GET_BLOCK = 3'd2,
    ST_GET_REG   = 3'd3,
    ST_GET_DATA  = 3'd4,
    ST_GET_INSTR = 3'd5,
    ST_STROBE    = 3'd6,
    ST_SWAP_WAIT = 3'd7
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_get(input state_e s);
    return (s == ST_GET_BLOCK) || (s == ST_GET_REG) ||
           (s == ST_GET_DATA)  || (s == ST_GET_INSTR);
  endfunction

  function automatic logic op_known(input logic [3:0] op);
    return (op >= OP_WRITE_INSTR) && (op <= OP_SET_OUTPUT_GAIN);
  endfunction

  // Opcodes whose pipeline index selects a strobe bit and so must be in range
  function automatic logic op_needs_pipe(input logic [3:0] op);
    return (op == OP_WRITE_INSTR) || (op == OP_WRITE_REG) ||
           (op == OP_UPDATE_REG)  || (op == OP_ALLOC_SRAM) ||
           (op == OP_RESET_PIPELINE);
  endfunction

endpackage

// File: rtl/control_unit_multi_collector.sv
// ctrl_byte_collector: byte intake for the command decoder.
// Owns the acceptance guard, the registered FIFO pop pulse, the MSB-first
// payload shift register, the payload byte counter and the idle timeout.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   in_byte/in_ready head of host FIFO and its non-empty flag
//   accept_en       current state may consume a byte
//   shift_en        accepted bytes are payload and go into shreg
//   idle_en         idle timeout counter runs in this state
//   start           entering a new GET/wait state: clear counters
//   n_bytes         payload bytes expected in the current state
//   accept          byte consumed this cycle (combinational)
//   done            last payload byte consumed this cycle (combinational)
//   expire          idle limit reached with no acceptance (combinational)
//   next            one-cycle pop pulse, the cycle after accept
//   shreg           assembled payload, newest byte in the low bits
module ctrl_byte_collector #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_ready,
  input  logic             accept_en,
  input  logic             shift_en,
  input  logic             idle_en,
  input  logic             start,
  input  logic [3:0]       n_bytes,
  output logic             accept,
  output logic             done,
  output logic             expire,
  output logic             next,
  output logic [WIDTH-1:0] shreg
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

  logic              guard;
  logic [3:0]        byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  // The FIFO head is still visible the cycle after a pop is requested, so
  // the guard blocks that stale byte from being taken twice.
  assign accept = accept_en && in_ready && !guard;
  assign done   = accept && shift_en && (byte_cnt == n_bytes - 4'd1);
  // Acceptance wins over expiry in the same cycle
  assign expire = idle_en && !accept &&
                  (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guard    <= 1'b0;
      next     <= 1'b0;
      shreg    <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      guard <= accept;
      next  <= accept;
      if (shift_en && accept) shreg <= WIDTH'({shreg, in_byte});
      if (start)                    byte_cnt <= '0;
      else if (shift_en && accept)  byte_cnt <= byte_cnt + 4'd1;
      if (start || accept)          idle_cnt <= '0;
      else if (idle_en && !expire)  idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/control_unit_multi.sv
// control_unit_multi: byte-stream command decoder for an array of DSP
// pipelines. Pops command and payload bytes from the host FIFO, decodes
// them and issues one-cycle per-pipeline strobes with their target,
// register, data and instruction buses.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_byte/in_ready/next host FIFO head, non-empty flag, pop pulse
//   block_target, reg_target, data_out, instr_out  command buses
//   block_instr_write, block_reg_write, block_reg_update,
//   alloc_sram_delay, reset_pipeline               one-hot strobes
//   swap_pipelines / pipelines_swapping            swap handshake
//   set_input_gain, set_output_gain                gain update pulses
//   invalid, timeout_err                           error pulses
//   control_state                                  current state
module control_unit_multi
  import control_unit_multi_pkg::*;
#(
  parameter int N_PIPELINES    = 4,
  parameter int N_BLOCKS       = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int INSTR_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_byte,
  input  logic                        in_ready,
  output logic                        next,
  output logic [$clog2(N_BLOCKS)-1:0] block_target,
  output logic [REG_ADDR_WIDTH-1:0]   reg_target,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic [INSTR_WIDTH-1:0]      instr_out,
  output logic [N_PIPELINES-1:0]      block_instr_write,
  output logic [N_PIPELINES-1:0]      block_reg_write,
  output logic [N_PIPELINES-1:0]      block_reg_update,
  output logic [N_PIPELINES-1:0]      alloc_sram_delay,
  output logic [N_PIPELINES-1:0]      reset_pipeline,
  output logic                        swap_pipelines,
  input  logic                        pipelines_swapping,
  output logic                        set_input_gain,
  output logic                        set_output_gain,
  output logic                        invalid,
  output logic                        timeout_err,
  output logic [7:0]                  control_state
);

  localparam int BW = $clog2(N_BLOCKS);
  localparam int SW = max_int(DATA_WIDTH, INSTR_WIDTH);

  state_e                    state, state_d;
  logic [7:0]                cmd_q;
  logic [BW-1:0]             blk_q;
  logic [REG_ADDR_WIDTH-1:0] reg_q;
  logic                      seen_swap;
  logic [3:0]                op, pipe;
  logic                      bad_cmd;
  logic [N_PIPELINES-1:0]    pipe_onehot;
  logic                      accept, done, expire, start;
  logic [SW-1:0]             shreg;

  assign op          = cmd_q[CMD_OP_MSB:CMD_OP_LSB];
  assign pipe        = cmd_q[CMD_PIPE_MSB:CMD_PIPE_LSB];
  assign bad_cmd     = !op_known(op) ||
                       (op_needs_pipe(op) && (32'(pipe) >= N_PIPELINES));
  assign pipe_onehot = N_PIPELINES'(1) << pipe;
  assign control_state = 8'(state);

  ctrl_byte_collector #(
    .WIDTH          (SW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_collector (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .accept_en ((state == ST_READY) || is_get(state)),
    .shift_en  ((state == ST_GET_DATA) || (state == ST_GET_INSTR)),
    .idle_en   (is_get(state) || (state == ST_SWAP_WAIT)),
    .start     (start),
    .n_bytes   ((state == ST_GET_INSTR) ? 4'(INSTR_WIDTH / 8) : 4'(DATA_WIDTH / 8)),
    .accept    (accept),
    .done      (done),
    .expire    (expire),
    .next      (next),
    .shreg     (shreg)
  );

  // Next-state logic
  always_comb begin
    // NOTE: default every combinational output up front so no path infers a latch.
    state_d = state;
    unique case (state)
      ST_READY:     if (accept) state_d = ST_BEGIN;
      ST_BEGIN: begin
        if (bad_cmd) state_d = ST_READY;
        else begin
          unique case (op)
            OP_WRITE_INSTR, OP_WRITE_REG, OP_UPDATE_REG: state_d = ST_GET_BLOCK;
            OP_SWAP:                                     state_d = ST_SWAP_WAIT;
            OP_RESET_PIPELINE:                           state_d = ST_READY;
            default:                                     state_d = ST_GET_DATA;
          endcase
        end
      end
      ST_GET_BLOCK: if (accept) state_d = (op == OP_WRITE_INSTR) ? ST_GET_INSTR : ST_GET_REG;
                    else if (expire) state_d = ST_READY;
      ST_GET_REG:   if (accept) state_d = ST_GET_DATA;
                    else if (expire) state_d = ST_READY;
      ST_GET_DATA,
      ST_GET_INSTR: if (done) state_d = ST_STROBE;
                    else if (expire) state_d = ST_READY;
      ST_STROBE:    state_d = ST_READY;
      ST_SWAP_WAIT: if (expire || (seen_swap && !pipelines_swapping)) state_d = ST_READY;
      default:      state_d = ST_READY;
    endcase
    start = (state_d != state) && (is_get(state_d) || (state_d == ST_SWAP_WAIT));
  end

  // State register and command field capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_READY;
      cmd_q     <= '0;
      blk_q     <= '0;
      reg_q     <= '0;
      seen_swap <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ST_READY && accept)     cmd_q <= in_byte;
      if (state == ST_GET_BLOCK && accept) blk_q <= in_byte[BW-1:0];
      if (state == ST_GET_REG && accept)   reg_q <= in_byte[REG_ADDR_WIDTH-1:0];
      if (state == ST_BEGIN)               seen_swap <= 1'b0;
      else if (state == ST_SWAP_WAIT && pipelines_swapping) seen_swap <= 1'b1;
    end
  end

  // Output logic: next values of the registered outputs
  logic                      fire, go;
  logic [BW-1:0]             block_target_d;
  logic [REG_ADDR_WIDTH-1:0] reg_target_d;
  logic [DATA_WIDTH-1:0]     data_out_d;
  logic [INSTR_WIDTH-1:0]    instr_out_d;

  always_comb begin
    fire           = (state == ST_STROBE);
    go             = (state == ST_BEGIN) && !bad_cmd;
    block_target_d = block_target;
    reg_target_d   = reg_target;
    data_out_d     = data_out;
    instr_out_d    = instr_out;
    if (fire) begin
      if (op == OP_WRITE_INSTR || op == OP_WRITE_REG || op == OP_UPDATE_REG)
        block_target_d = blk_q;
      if (op == OP_WRITE_REG || op == OP_UPDATE_REG)
        reg_target_d = reg_q;
      if (op == OP_WRITE_INSTR) instr_out_d = shreg[INSTR_WIDTH-1:0];
      else                      data_out_d  = shreg[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_target      <= '0;
      reg_target        <= '0;
      data_out          <= '0;
      instr_out         <= '0;
      block_instr_write <= '0;
      block_reg_write   <= '0;
      block_reg_update  <= '0;
      alloc_sram_delay  <= '0;
      reset_pipeline    <= '0;
      swap_pipelines    <= 1'b0;
      set_input_gain    <= 1'b0;
      set_output_gain   <= 1'b0;
      invalid           <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      block_target      <= block_target_d;
      reg_target        <= reg_target_d;
      data_out          <= data_out_d;
      instr_out         <= instr_out_d;
      block_instr_write <= (fire && op == OP_WRITE_INSTR) ? pipe_onehot : '0;
      block_reg_write   <= (fire && op == OP_WRITE_REG)   ? pipe_onehot : '0;
      block_reg_update  <= (fire && op == OP_UPDATE_REG)  ? pipe_onehot : '0;
      alloc_sram_delay  <= (fire && op == OP_ALLOC_SRAM)  ? pipe_onehot : '0;
      reset_pipeline    <= (go && op == OP_RESET_PIPELINE) ? pipe_onehot : '0;
      swap_pipelines    <= go && (op == OP_SWAP);
      set_input_gain    <= fire && (op == OP_SET_INPUT_GAIN);
      set_output_gain   <= fire && (op == OP_SET_OUTPUT_GAIN);
      invalid           <= (state == ST_BEGIN) && bad_cmd;
      timeout_err       <= expire;
    end
  end

endmodule

// File: tb/tb_control_unit_multi.sv
// Directed bench for control_unit_multi. A small FIFO model feeds bytes
// and pops on next; a negedge monitor logs strobe counts, values and the
// cycle they appeared in. Expected cycles are offsets from the cycle the
// command byte was pushed (and therefore accepted).
module tb_control_unit_multi;

  localparam int NP = 4;
  localparam int T  = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        next;
  logic [4:0]  block_target;
  logic [3:0]  reg_target;
  logic [15:0] data_out;
  logic [31:0] instr_out;
  logic [NP-1:0] block_instr_write, block_reg_write, block_reg_update;
  logic [NP-1:0] alloc_sram_delay, reset_pipeline;
  logic        swap_pipelines, pipelines_swapping;
  logic        set_input_gain, set_output_gain, invalid, timeout_err;
  logic [7:0]  control_state;

  always #5 clk = ~clk;

  control_unit_multi #(
    .N_PIPELINES(NP), .N_BLOCKS(32), .REG_ADDR_WIDTH(4),
    .DATA_WIDTH(16), .INSTR_WIDTH(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_ready(in_ready),
    .next(next), .block_target(block_target), .reg_target(reg_target),
    .data_out(data_out), .instr_out(instr_out),
    .block_instr_write(block_instr_write), .block_reg_write(block_reg_write),
    .block_reg_update(block_reg_update), .alloc_sram_delay(alloc_sram_delay),
    .reset_pipeline(reset_pipeline), .swap_pipelines(swap_pipelines),
    .pipelines_swapping(pipelines_swapping), .set_input_gain(set_input_gain),
    .set_output_gain(set_output_gain), .invalid(invalid),
    .timeout_err(timeout_err), .control_state(control_state)
  );

  // Host FIFO model
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign in_ready = (rd_ptr != wr_ptr);
  assign in_byte  = mem[rd_ptr];
  always @(posedge clk) if (next && in_ready) rd_ptr <= rd_ptr + 8'd1;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Cycle counter and event monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_next = 0, n_iw = 0, n_rw = 0, n_ru = 0, n_al = 0, n_rp = 0;
  int n_sw = 0, n_ig = 0, n_og = 0, n_inv = 0, n_to = 0;
  int iw_cyc, rw_cyc, ru_cyc, al_cyc, rp_cyc, sw_cyc, og_cyc, inv_cyc, to_cyc;
  logic [NP-1:0] iw_val, rw_val, ru_val, al_val, rp_val;

  always @(negedge clk) begin
    if (next) n_next <= n_next + 1;
    if (block_instr_write != 0) begin n_iw <= n_iw + 1; iw_val <= block_instr_write; iw_cyc <= cyc; end
    if (block_reg_write != 0)   begin n_rw <= n_rw + 1; rw_val <= block_reg_write;   rw_cyc <= cyc; end
    if (block_reg_update != 0)  begin n_ru <= n_ru + 1; ru_val <= block_reg_update;  ru_cyc <= cyc; end
    if (alloc_sram_delay != 0)  begin n_al <= n_al + 1; al_val <= alloc_sram_delay;  al_cyc <= cyc; end
    if (reset_pipeline != 0)    begin n_rp <= n_rp + 1; rp_val <= reset_pipeline;    rp_cyc <= cyc; end
    if (swap_pipelines)  begin n_sw  <= n_sw + 1;  sw_cyc  <= cyc; end
    if (set_input_gain)  n_ig <= n_ig + 1;
    if (set_output_gain) begin n_og  <= n_og + 1;  og_cyc  <= cyc; end
    if (invalid)         begin n_inv <= n_inv + 1; inv_cyc <= cyc; end
    if (timeout_err)     begin n_to  <= n_to + 1;  to_cyc  <= cyc; end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int n0, b0, b1, b2;

  initial begin
    reset = 1'b1;
    pipelines_swapping = 1'b0;
    tick(3);
    check("rst_state", control_state, 8'h00);
    check("rst_next", next, 1'b0);
    check("rst_data", data_out, 16'h0);
    check("rst_strobes", {block_reg_write, block_instr_write, reset_pipeline}, 12'h0);
    reset = 1'b0;
    tick(2);

    // WRITE_REG pipeline 2: four payload bytes, strobe 10 cycles after accept
    n0 = cyc; b0 = n_next; b1 = n_rw;
    push(8'h22); push(8'h05); push(8'h03); push(8'hAB); push(8'hCD);
    tick(14);
    check("wr_cycle", rw_cyc, n0 + 10);
    check("wr_onehot", rw_val, 4'b0100);
    check("wr_width", n_rw - b1, 1);
    check("wr_block", block_target, 5'd5);
    check("wr_reg", reg_target, 4'd3);
    check("wr_data", data_out, 16'hABCD);
    check("wr_next_cnt", n_next - b0, 5);
    check("wr_ready", control_state, 8'h00);

    // WRITE_INSTR pipeline 0: five payload bytes
    n0 = cyc; b1 = n_iw;
    push(8'h10); push(8'h1F); push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
    tick(16);
    check("wi_cycle", iw_cyc, n0 + 12);
    check("wi_onehot", iw_val, 4'b0001);
    check("wi_width", n_iw - b1, 1);
    check("wi_block", block_target, 5'd31);
    check("wi_instr", instr_out, 32'hDEADBEEF);
    check("wi_data_hold", data_out, 16'hABCD);

    // UPDATE_REG pipeline 3 with block/reg bytes needing truncation
    n0 = cyc; b1 = n_rw; b2 = n_ru;
    push(8'h33); push(8'hE7); push(8'hF9); push(8'h12); push(8'h34);
    tick(14);
    check("ur_cycle", ru_cyc, n0 + 10);
    check("ur_onehot", ru_val, 4'b1000);
    check("ur_block", block_target, 5'd7);
    check("ur_reg", reg_target, 4'd9);
    check("ur_data", data_out, 16'h1234);
    check("ur_no_write", n_rw - b1, 0);

    // Out-of-range pipeline index, then a good command
    n0 = cyc; b0 = n_rp + n_rw + n_ru + n_iw + n_al; b1 = n_inv;
    push(8'h25);
    tick(4);
    check("inv_p_cycle", inv_cyc, n0 + 2);
    check("inv_p_count", n_inv - b1, 1);
    check("inv_p_nostrobe", n_rp + n_rw + n_ru + n_iw + n_al - b0, 0);
    n0 = cyc;
    push(8'h61);
    tick(4);
    check("rp_cycle", rp_cyc, n0 + 2);
    check("rp_onehot", rp_val, 4'b0010);
    n0 = cyc; b1 = n_inv;
    push(8'hF0);
    tick(4);
    check("inv_op_cycle", inv_cyc, n0 + 2);
    check("inv_op_count", n_inv - b1, 1);

    // Data-only commands; SET_OUTPUT_GAIN ignores the index field
    n0 = cyc;
    push(8'h41); push(8'h56); push(8'h78);
    tick(9);
    check("al_cycle", al_cyc, n0 + 6);
    check("al_onehot", al_val, 4'b0010);
    check("al_data", data_out, 16'h5678);
    n0 = cyc; b1 = n_inv;
    push(8'h8F); push(8'hBE); push(8'hEF);
    tick(9);
    check("og_cycle", og_cyc, n0 + 6);
    check("og_data", data_out, 16'hBEEF);
    check("og_no_inv", n_inv - b1, 0);

    // Timeout mid-payload: one data byte then the FIFO runs dry
    n0 = cyc; b0 = n_ig; b1 = n_to;
    push(8'h70); push(8'h12);
    tick(T + 6);
    check("to_cycle", to_cyc, n0 + T + 3);
    check("to_count", n_to - b1, 1);
    check("to_no_gain", n_ig - b0, 0);
    check("to_ready", control_state, 8'h00);
    check("to_data_kept", data_out, 16'hBEEF);
    n0 = cyc;
    push(8'h61);
    tick(4);
    check("to_resume", rp_cyc, n0 + 2);

    // Swap with handshake
    n0 = cyc; b1 = n_to;
    push(8'h50);
    tick(3);
    check("sw_cycle", sw_cyc, n0 + 2);
    check("sw_wait", control_state, 8'h07);
    pipelines_swapping = 1'b1;
    tick(6);
    check("sw_busy", control_state, 8'h07);
    pipelines_swapping = 1'b0;
    tick(1);
    check("sw_done", control_state, 8'h00);
    check("sw_no_to", n_to - b1, 0);

    // Swap that never starts: index ignored, timeout from SWAP_WAIT
    n0 = cyc; b0 = n_sw; b1 = n_to;
    push(8'h5F);
    tick(T + 5);
    check("sw2_pulse", n_sw - b0, 1);
    check("sw2_to_cycle", to_cyc, n0 + T + 2);
    check("sw2_ready", control_state, 8'h00);

    // Asynchronous reset between data bytes
    b0 = n_ru;
    push(8'h33); push(8'h01); push(8'h02); push(8'hAA);
    tick(9);
    check("ar_mid", control_state, 8'h04);
    reset = 1'b1;
    #1;
    check("ar_state", control_state, 8'h00);
    check("ar_data", data_out, 16'h0000);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("ar_no_strobe", n_ru - b0, 0);
    n0 = cyc; b1 = n_rw;
    push(8'h22); push(8'h05); push(8'h03); push(8'hAB); push(8'hCD);
    tick(14);
    check("ar_clean_cycle", rw_cyc, n0 + 10);
    check("ar_clean_count", n_rw - b1, 1);
    check("ar_clean_data", data_out, 16'hABCD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
